// File: rtl/led_blink_pkg.sv
// Shared constants, direction encoding and helpers for the LED blink/fade path.
package led_blink_pkg;

  localparam int unsigned LED_COUNT        = 8;
  localparam int unsigned PWM_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  // Full-scale duty for a given PWM counter width.
  function automatic int unsigned duty_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: duty ramp toward the on/off target, period-aligned shadow
// copy of the duty, and the registered PWM comparator.
module led_fade_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned PWM_BITS  = PWM_BITS_DEFAULT,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                pwm_wrap_i,
  input  logic                led_s_i,
  input  logic                fade_en_i,
  output logic                led_o
);

  localparam int unsigned         DUTY_MAX  = duty_max(PWM_BITS);
  localparam int unsigned         SUM_W     = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(FADE_STEP);
  localparam logic [SUM_W-1:0]    SUM_LIMIT = SUM_W'(DUTY_MAX);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                led_q, led_d;
  logic [PWM_BITS-1:0] tgt_c;
  logic [SUM_W-1:0]    up_sum_c;
  dir_e                dir_c;

  // Ramp decision, saturating step, shadow reload and PWM compare.
  always_comb begin
    tgt_c    = led_s_i ? DUTY_FULL : '0;
    dir_c    = DIR_HOLD;
    up_sum_c = {1'b0, duty_q} + {1'b0, STEP};
    duty_d   = duty_q;
    shadow_d = shadow_q;
    led_d    = 1'b0;

    if (duty_q < tgt_c) begin
      dir_c = DIR_UP;
    end else if (duty_q > tgt_c) begin
      dir_c = DIR_DOWN;
    end

    if (!fade_en_i) begin
      duty_d = tgt_c;
    end else if (tick_i) begin
      unique case (dir_c)
        DIR_UP:   duty_d = (up_sum_c > SUM_LIMIT) ? DUTY_FULL : up_sum_c[PWM_BITS-1:0];
        DIR_DOWN: duty_d = (duty_q < STEP) ? '0 : duty_q - STEP;
        default:  duty_d = duty_q;
      endcase
    end

    // Duty only reaches the comparator at a period boundary to avoid glitches.
    if (pwm_wrap_i) begin
      shadow_d = duty_q;
    end
    led_d = (shadow_q > pwm_cnt_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED output stage: synchronises the on/off pattern and drives each pin with a
// PWM whose duty fades (or snaps) toward the requested state.
module led_pwm_fader
  import led_blink_pkg::*;
#(
  parameter int unsigned PWM_BITS  = PWM_BITS_DEFAULT,
  parameter int unsigned STEP_DIV  = 1024,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic                 clock,
  input  logic                 MSS_RESET_N,
  input  logic [LED_COUNT-1:0] led_in,
  input  logic                 fade_en,
  output logic [LED_COUNT-1:0] LED
);

  localparam int unsigned         DUTY_MAX  = duty_max(PWM_BITS);
  localparam int unsigned         STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(DUTY_MAX - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [LED_COUNT-1:0] sync1_q;
  logic [LED_COUNT-1:0] led_s_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic                 pwm_wrap_c;
  logic                 tick_c;
  logic [LED_COUNT-1:0] ch_led;

  // PWM period counter (DUTY_MAX cycles) and fade-step prescaler.
  always_comb begin
    pwm_wrap_c = (pwm_cnt_q == PWM_LAST);
    tick_c     = (step_cnt_q == STEP_LAST);
    pwm_cnt_d  = pwm_wrap_c ? '0 : pwm_cnt_q + PWM_BITS'(1);
    step_cnt_d = tick_c ? '0 : step_cnt_q + STEP_W'(1);
  end

  always_ff @(posedge clock or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      sync1_q    <= '0;
      led_s_q    <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else begin
      sync1_q    <= led_in;
      led_s_q    <= sync1_q;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk        (clock),
      .rst_n      (MSS_RESET_N),
      .tick_i     (tick_c),
      .pwm_cnt_i  (pwm_cnt_q),
      .pwm_wrap_i (pwm_wrap_c),
      .led_s_i    (led_s_q[i]),
      .fade_en_i  (fade_en),
      .led_o      (ch_led[i])
    );
  end

  assign LED = ch_led;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader with a cycle-count based reference model.
module tb_led_pwm_fader;

  localparam int unsigned P_PWM_BITS  = 4;
  localparam int unsigned P_STEP_DIV  = 4;
  localparam int unsigned P_FADE_STEP = 4;
  localparam int DMAX = 15;
  localparam int SDIV = 4;
  localparam int FS   = 4;

  logic       clock;
  logic       MSS_RESET_N;
  logic [7:0] led_in;
  logic       fade_en;
  logic [7:0] LED;

  int total;
  int bad;

  // reference model state: edges since reset, per-channel duty/shadow, 2-deep input history
  int         m_n;
  int         m_duty[8];
  int         m_shadow[8];
  logic [7:0] m_led;
  logic [7:0] m_h1;
  logic [7:0] m_h2;

  typedef struct {
    logic [7:0] li;
    logic       fe;
    int         run;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[10];

  led_pwm_fader #(
    .PWM_BITS  (P_PWM_BITS),
    .STEP_DIV  (P_STEP_DIV),
    .FADE_STEP (P_FADE_STEP)
  ) dut (
    .clock       (clock),
    .MSS_RESET_N (MSS_RESET_N),
    .led_in      (led_in),
    .fade_en     (fade_en),
    .LED         (LED)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n   = 0;
    m_led = 8'h00;
    m_h1  = 8'h00;
    m_h2  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_duty[i]   = 0;
      m_shadow[i] = 0;
    end
  endtask

  // One clock edge: PWM phase is edges mod period, tick is every SDIV-th edge.
  task automatic model_step(input logic [7:0] li, input logic fe);
    int k;
    int tgt;
    bit tick;
    k    = m_n % DMAX;
    tick = ((m_n % SDIV) == SDIV - 1);
    for (int i = 0; i < 8; i++) begin
      m_led[i] = (m_shadow[i] > k);
      if (k == DMAX - 1) m_shadow[i] = m_duty[i];
      tgt = m_h2[i] ? DMAX : 0;
      if (!fe) begin
        m_duty[i] = tgt;
      end else if (tick) begin
        if (m_duty[i] < tgt)      m_duty[i] = (m_duty[i] + FS > DMAX) ? DMAX : m_duty[i] + FS;
        else if (m_duty[i] > tgt) m_duty[i] = (m_duty[i] < FS) ? 0 : m_duty[i] - FS;
      end
    end
    m_h2 = m_h1;
    m_h1 = li;
    m_n++;
  endtask

  // Called at a negedge: drive, clock once, compare against the model.
  task automatic run_cycle(input logic [7:0] li, input logic fe);
    led_in  = li;
    fade_en = fe;
    @(posedge clock);
    model_step(li, fe);
    @(negedge clock);
    check("led_vs_model", LED, m_led);
  endtask

  task automatic do_reset(input logic [7:0] li, input int n);
    MSS_RESET_N = 1'b0;
    led_in      = li;
    #1;
    check("led_in_reset", LED, 8'h00);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      check("led_in_reset", LED, 8'h00);
    end
    model_reset();
    MSS_RESET_N = 1'b1;
  endtask

  int         cnt;
  bit         found;
  logic [7:0] r_li;
  logic       r_fe;

  initial begin
    total       = 0;
    bad         = 0;
    MSS_RESET_N = 1'b1;
    led_in      = 8'h00;
    fade_en     = 1'b1;
    model_reset();

    vecs[0] = '{8'h00, 1'b1, 40, 8'h00};
    vecs[1] = '{8'hA5, 1'b1, 40, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 40, 8'h5A};
    vecs[3] = '{8'h41, 1'b0, 22, 8'h41};
    vecs[4] = '{8'h49, 1'b0, 22, 8'h49};
    vecs[5] = '{8'hF0, 1'b1, 40, 8'hF0};
    vecs[6] = '{8'h0F, 1'b0, 22, 8'h0F};
    vecs[7] = '{8'hFF, 1'b1, 40, 8'hFF};
    vecs[8] = '{8'h00, 1'b0, 22, 8'h00};
    vecs[9] = '{8'h3C, 1'b1, 40, 8'h3C};

    #2;
    // Reset with all inputs high, then ramp 0,4,8,12,15 seen through the PWM.
    do_reset(8'hFF, 5);
    cnt = 0;
    repeat (15) begin run_cycle(8'hFF, 1'b1); if (LED[0]) cnt++; end
    check_int("ramp_period0_highs", cnt, 0);
    cnt = 0;
    repeat (15) begin run_cycle(8'hFF, 1'b1); if (LED[0]) cnt++; end
    check_int("ramp_period1_highs", cnt, 12);
    repeat (30) begin run_cycle(8'hFF, 1'b1); check("ramp_full_on", LED, 8'hFF); end

    // Table: apply a pattern, let it settle, then the output must be constant.
    for (int v = 0; v < 10; v++) begin
      repeat (vecs[v].run) run_cycle(vecs[v].li, vecs[v].fe);
      repeat (DMAX) begin
        run_cycle(vecs[v].li, vecs[v].fe);
        check($sformatf("settled_vec%0d", v), LED, vecs[v].exp_led);
      end
    end

    // PWM duty: find a period whose shadow is 8 and count high cycles.
    found = 0;
    for (int d = 0; d < 15 && !found; d++) begin
      do_reset(8'h00, 2);
      repeat (d) run_cycle(8'h00, 1'b1);
      for (int c = 0; c < 60 && !found; c++) begin
        run_cycle(8'h01, 1'b1);
        if ((m_n % DMAX) == 0 && m_shadow[0] == 8) found = 1;
      end
    end
    check_int("pwm8_setup_found", int'(found), 1);
    if (found) begin
      cnt = 0;
      repeat (15) begin run_cycle(8'h01, 1'b1); if (LED[0]) cnt++; end
      check_int("pwm8_high_count", cnt, 8);
    end

    // Reversal: ch0 turns off when its duty reaches 8, ch1 keeps ramping up.
    do_reset(8'h00, 2);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      run_cycle(8'h03, 1'b1);
      if (m_duty[0] == 8) found = 1;
    end
    check_int("reversal_reach8", int'(found), 1);
    repeat (40) run_cycle(8'h02, 1'b1);
    repeat (15) begin
      run_cycle(8'h02, 1'b1);
      check("reversal_settled", LED, 8'h02);
    end

    // Reset mid-fade: duty 12 with the output high, reset must clear LED at once.
    found = 0;
    for (int d = 0; d < 15 && !found; d++) begin
      do_reset(8'h00, 2);
      repeat (d) run_cycle(8'h00, 1'b1);
      for (int c = 0; c < 40 && !found; c++) begin
        run_cycle(8'h01, 1'b1);
        if (m_duty[0] == 12 && m_led[0]) found = 1;
      end
    end
    check_int("midfade_setup_found", int'(found), 1);
    #2;
    MSS_RESET_N = 1'b0;
    #1;
    check("midfade_async_clear", LED, 8'h00);
    @(negedge clock);
    do_reset(8'h01, 3);
    cnt = 0;
    repeat (15) begin run_cycle(8'h01, 1'b1); if (LED[0]) cnt++; end
    check_int("midfade_restart_p0", cnt, 0);
    cnt = 0;
    repeat (15) begin run_cycle(8'h01, 1'b1); if (LED[0]) cnt++; end
    check_int("midfade_restart_p1", cnt, 12);

    // Random patterns and fade mode against the model, with one reset inside.
    r_li = 8'h00;
    r_fe = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15, 0) == 0) r_li = 8'($urandom);
      if ($urandom_range(63, 0) == 0) r_fe = ~r_fe;
      if (c == 700) do_reset(r_li, 2);
      run_cycle(r_li, r_fe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream output stage between `led_control` and the board LED pins. It takes the 8-bit on/off pattern from `led_control`, synchronises it into the fabric clock domain, and ramps a per-LED PWM duty cycle toward full-on or full-off so each LED fades rather than snapping. It runs directly on `FAB_CLK`, not on the divided clock. Its registered `LED` output replaces the direct `LED_net_0` connection in the top level.

## Interface
- `PWM_BITS`, default 8: duty and PWM counter width; `DUTY_MAX` = 2^PWM_BITS − 1.
- `STEP_DIV`, default 1024: `clock` cycles per fade step tick; legal range ≥ 2.
- `FADE_STEP`, default 4: duty increment or decrement applied per tick; legal range 1..DUTY_MAX.
- `clock`  in  1  fabric clock (`FAB_CLK`); the only clock.
- `MSS_RESET_N`  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to `clock`.
- `led_in`  in  8  on/off pattern from `led_control`; asynchronous to `clock`.
- `fade_en`  in  1  synchronous to `clock`. 1 = fade; 0 = snap.
- `LED`  out  8  registered PWM drive to the pins.

## Operation
- **Input sync:** each `led_in` bit passes through a 2-flop synchroniser, giving `led_s[i]`. Target duty is `tgt[i]` = `led_s[i]` ? DUTY_MAX : 0.
- **PWM counter:** `pwm_cnt` counts 0..DUTY_MAX−1, then wraps to 0. The period is DUTY_MAX cycles.
- **Output:** `LED[i]` <= (`shadow[i]` > `pwm_cnt`), registered.
  - Duty 0 gives an output that is never high.
  - Duty DUTY_MAX gives an output that is always high.
- **Shadow load:** `shadow[i]` <= `duty[i]` only on the cycle where `pwm_cnt` == DUTY_MAX−1. Duty therefore changes only at PWM period boundaries, so there are no mid-period glitches.
- **Step prescaler:** `step_cnt` counts 0..STEP_DIV−1. `tick` is asserted for one cycle when `step_cnt` == STEP_DIV−1; the counter then wraps.
- **Per-channel ramp (`fade_en` = 1):** on `tick` each channel takes one of three actions.
  - UP, when `duty` < `tgt`: `duty` <= min(`duty` + FADE_STEP, DUTY_MAX). Compute in PWM_BITS+1 bits to saturate; never wrap.
  - DOWN, when `duty` > `tgt`: `duty` <= (`duty` < FADE_STEP) ? 0 : `duty` − FADE_STEP.
  - HOLD, when equal: no change.
  - When not on `tick`, `duty` holds.
- **Snap (`fade_en` = 0):** `duty` <= `tgt` every cycle, independent of `tick`.
- **Target reversal mid-ramp:** the direction reverses at the next tick, starting from the current `duty`. There is no restart from an endpoint.
- **Reset:**
  - Values: the synchronisers, `pwm_cnt`, `step_cnt`, every `duty` and `shadow` clear to 0, and `LED` = 8'h00.
  - Mid-fade: assertion during a fade clears everything immediately, asynchronously.
  - After release: a channel whose `led_in` bit is held high ramps up from 0.

## Timing
- `led_in` edge to `led_s`: 2 cycles.
- `led_s` to first `duty` change:
  - `fade_en` = 1: the next `tick`, up to STEP_DIV cycles later.
  - `fade_en` = 0: 1 cycle.
- `duty` to `LED` effect: up to DUTY_MAX cycles for the shadow load, plus 1 cycle for the output register.
- Full fade 0 to DUTY_MAX: ceil(DUTY_MAX / FADE_STEP) ticks. At defaults this is 64 × 1024 cycles.
- All 8 channels step on the same `tick`. They are independent in direction.

## Structure
- Shared package `led_blink_pkg` holds:
  - `LED_COUNT` = 8;
  - the `PWM_BITS` default;
  - `DUTY_MAX` derivation;
  - the UP/DOWN/HOLD direction encoding.
- Top level holds the synchronisers, `pwm_cnt`, the step prescaler and the 8 instances.
- Sub-module `led_fade_channel`, one per LED, holds that channel's `duty`, `shadow`, ramp logic and output comparator. It takes `tick`, `pwm_cnt`, the wrap strobe, `led_s[i]` and `fade_en`.

## Test plan
Bench parameters: PWM_BITS = 4 (DUTY_MAX = 15), STEP_DIV = 4, FADE_STEP = 4.
- **Reset:** assert `MSS_RESET_N` = 0 with `led_in` = 8'hFF.
  - `LED` = 0 for the whole of reset.
  - After release, `duty` rises 0, 4, 8, 12, 15, one step every 4 cycles, then holds at 15.
  - `LED` is constant 1 once `shadow` = 15.
- **Fade down, saturating:** all `duty` at 15, set `led_in` = 8'h00.
  - `duty` falls 15, 11, 7, 3, 0.
  - Never wraps below 0; `LED` ends constant 0.
- **Snap:** `fade_en` = 0, toggle `led_in[3]` 0 → 1.
  - `duty[3]` = 15 three cycles after the edge.
  - `LED[3]` is constant high from the next PWM period.
  - All other bits are unchanged.
- **PWM duty check:** with `shadow` = 8, `LED` is high for exactly 8 of each 15 cycles. `shadow` changes only on `pwm_cnt` wrap.
- **Reversal:** `led_in[0]` rises, then falls when `duty[0]` = 8.
  - The next tick gives `duty[0]` = 4, then 0.
  - Channel 1 meanwhile ramps up independently.
- **Reset mid-fade:** assert reset when `duty` = 12.
  - `LED` = 0 asynchronously, in the same cycle.
  - After release, the ramp restarts from 0.
